// File: rtl/dcm_prog_ctrl.sv
// DCM dynamic-programming controller: selects a slow-clock mode,
// strobes it into the clock manager and waits for confirmation.
module dcm_prog_ctrl #(
  parameter int MAX_MODE    = 7,
  parameter int UPD_HOLD    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       apply,
  input  logic [2:0] prog_out,
  output logic [2:0] prog_in,
  output logic       update,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int HW = $clog2(UPD_HOLD + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]    LP_MAX  = 3'(MAX_MODE);
  localparam logic [HW-1:0] LP_HEND = HW'(UPD_HOLD - 1);
  localparam logic [WW-1:0] LP_WEND = WW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        r_state, w_state;
  logic [2:0]    r_sel, w_sel;
  logic [2:0]    r_prog, w_prog;
  logic [HW-1:0] r_hcnt, w_hcnt;
  logic [WW-1:0] r_wcnt, w_wcnt;
  logic          r_done, w_done;
  logic          r_err, w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_prog  <= '0;
      r_hcnt  <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_prog  <= w_prog;
      r_hcnt  <= w_hcnt;
      r_wcnt  <= w_wcnt;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_prog  = r_prog;
    w_hcnt  = r_hcnt;
    w_wcnt  = r_wcnt;
    w_done  = 1'b0;
    w_err   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (apply) begin
          w_prog  = r_sel;
          w_err   = 1'b0;
          w_hcnt  = '0;
          w_state = S_ISSUE;
        end else if (inc && !dec) begin
          if (r_sel < LP_MAX) w_sel = r_sel + 3'd1;
        end else if (dec && !inc) begin
          if (r_sel != 3'd0) w_sel = r_sel - 3'd1;
        end
      end
      S_ISSUE: begin
        if (r_hcnt == LP_HEND) begin
          w_wcnt  = '0;
          w_state = S_WAIT;
        end else begin
          w_hcnt = r_hcnt + 1'b1;
        end
      end
      S_WAIT: begin
        // a match wins over a timeout landing on the same cycle
        if (prog_out == r_prog) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else if (r_wcnt == LP_WEND) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_wcnt = r_wcnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // decoded from state so reset drops them without a clock edge
  assign update  = (r_state == S_ISSUE);
  assign busy    = (r_state != S_IDLE);
  assign sel     = r_sel;
  assign prog_in = r_prog;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: doc/dcm_prog_ctrl.md
DCM_PROG_CTRL -- requirements
Module: dcm_prog_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_MODE, default 7: highest selectable slow-clock mode (0..7).
REQ-002 The block SHALL have parameter UPD_HOLD, default 4: number of clk cycles that update is held high per request (>=1).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16: number of WAIT cycles allowed before error (>=1).
REQ-004 The block SHALL have port clk  input  1  100 MHz system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-006 The block SHALL have port inc  input  1  single-cycle pulse, raise pending selection.
REQ-007 The block SHALL have port dec  input  1  single-cycle pulse, lower pending selection.
REQ-008 The block SHALL have port apply  input  1  single-cycle pulse, commit pending selection to the clock manager.
REQ-009 The block SHALL have port prog_out  input  3  mode currently reported by the clock manager.
REQ-010 The block SHALL have port prog_in  output  3  target mode driven to the clock manager.
REQ-011 The block SHALL have port update  output  1  update strobe to the clock manager.
REQ-012 The block SHALL have port sel  output  3  pending (uncommitted) selection, for display.
REQ-013 The block SHALL have port busy  output  1  high while a request is in flight.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse on confirmed commit.
REQ-015 The block SHALL have port err  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and WAIT; busy SHALL be 1 exactly in ISSUE and WAIT.
REQ-017 sel SHALL update only in IDLE, on cycles without apply:
- inc alone: sel+1, saturating at MAX_MODE.
- dec alone: sel-1, saturating at 0.
- inc and dec together: no change.
REQ-018 inc and dec SHALL be ignored while busy and on any cycle where apply is accepted.
REQ-019 In IDLE, apply sampled at edge N SHALL, at that edge:
- latch target = sel (pre-edge value) into prog_in;
- set update = 1 and busy = 1;
- clear err;
- go to ISSUE.
REQ-020 In ISSUE, update SHALL stay high for exactly UPD_HOLD cycles, then deassert at the edge entering WAIT.
REQ-021 In WAIT, prog_out SHALL be compared to prog_in each cycle; on the first match, at that edge:
- done = 1 for one cycle;
- busy = 0;
- return to IDLE.
REQ-022 In WAIT, if no match occurs in TIMEOUT_CYC cycles, then at the edge ending the TIMEOUT_CYC-th cycle:
- err = 1;
- busy = 0;
- return to IDLE;
- done stays 0.
REQ-023 The WAIT cycle counter SHALL be cleared on entry to WAIT and SHALL be wide enough that it never wraps for the chosen TIMEOUT_CYC.
REQ-024 apply SHALL be ignored while busy: no queuing, and no change to prog_in or counters.
REQ-025 prog_in SHALL hold its last committed value in IDLE, including after a timeout.
REQ-026 A match on the first WAIT cycle SHALL complete the request; apply with sel equal to prog_out SHALL still run the full ISSUE/WAIT sequence.
REQ-027 err SHALL remain 1 until the next accepted apply or reset.

Reset
REQ-028 When rst is asserted, asynchronously and regardless of state, the block SHALL force:
- state = IDLE;
- sel = 0, prog_in = 0;
- update, busy, done, err = 0;
- all counters = 0.
REQ-029 Reset asserted during ISSUE SHALL drop update immediately, without waiting for a clock edge.
REQ-030 After rst deasserts, the first rising edge SHALL be a normal IDLE cycle.

Verification
REQ-031 Reset then 3 inc pulses -> sel = 3, busy = 0, prog_in = 0.
REQ-032 8 inc pulses from reset -> sel saturates at 7; then inc and dec in the same cycle -> sel stays 7; 8 dec pulses -> sel = 0.
REQ-033 sel = 5, apply at edge N, prog_out driven to 5 from edge N+6 (defaults) ->
- update high for cycles N+1..N+4;
- done = 1 for one cycle after the match;
- busy = 0 and prog_in = 5 afterwards.
REQ-034 sel = 2, apply, prog_out held at 0 -> after 4 update cycles plus 16 WAIT cycles: err = 1, busy = 0, done never pulses; next apply clears err.
REQ-035 apply, then apply and inc pulsed while busy -> only one update burst occurs, and sel is unchanged by the ignored inc.
REQ-036 rst asserted mid-ISSUE -> update, busy and prog_in go to 0 before the next clock edge; normal operation resumes after rst deasserts.
